instr_mem_responder: RTL
========================

Name: instr_mem_responder

Overview:
- Synthesizable responder end of the LC-3 instruction-memory bus (PC, instrmem_rd -> instr_dout, complete_instr).
- Sits opposite the fetch stage. Serves as the instruction ROM/RAM model in the UVMF bench and as the emulation-side memory.
- Accepts one fetch request at a time, returns the addressed 16-bit word after a programmable latency, and signals completion with a one-cycle pulse.
- Includes a side-band preload port and a fetch counter.

Parameters:
- ADDR_W, 8, word-address bits implemented; memory depth = 2**ADDR_W words.
- LATENCY, 1, cycles from request acceptance to complete_instr; legal range 1..15.
- ERR_WORD, 16'h0000, word returned for out-of-range PC.

Ports:
- clock  input  1  bus clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC  input  16  fetch word address from initiator.
- instrmem_rd  input  1  fetch request, level-sensitive.
- instr_dout  output  16  fetched instruction word.
- complete_instr  output  1  one-cycle pulse; instr_dout valid this cycle.
- ld_en  input  1  preload write enable.
- ld_addr  input  ADDR_W  preload word address.
- ld_data  input  16  preload data.
- addr_err  output  1  one-cycle pulse with complete_instr when PC was out of range.
- busy  output  1  high from acceptance through the response cycle.
- fetch_count  output  16  completed fetches; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock (clock). reset is asynchronous and active-high.
- Reset values: instr_dout=0, complete_instr=0, addr_err=0, busy=0, fetch_count=0, FSM=IDLE, latency counter=0. Memory array is not reset; contents survive reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if instrmem_rd=1 at a clock edge, capture PC into pc_q, load counter with LATENCY-1, set busy. Go to RESP if LATENCY=1, else WAIT.
  - WAIT: decrement counter each cycle. When counter reaches 1, go to RESP.
  - RESP (exactly one cycle):
    - complete_instr=1.
    - instr_dout = mem[pc_q[ADDR_W-1:0]], or ERR_WORD if pc_q[15:ADDR_W] != 0. In the error case addr_err=1.
    - fetch_count increments (saturating).
    - Next state is IDLE.
- Latency: the first cycle in which complete_instr is high is LATENCY cycles after the accepting edge.
- busy: high in WAIT and RESP, low in IDLE.
- Back-to-back: instrmem_rd still high in the IDLE cycle after RESP is a new request. Minimum request spacing is LATENCY+1 cycles.
- PC is sampled only at acceptance. PC changes during WAIT/RESP are ignored.
- instrmem_rd deasserted during WAIT does not abort; the response is still delivered.
- instr_dout holds its last response value until the next RESP. complete_instr and addr_err are single-cycle pulses.
- Preload: ld_en=1 writes ld_data to mem[ld_addr] at the edge, in any state.
  - Preload to the address being read in RESP in the same cycle returns the old data (read-before-write). The new data is visible to the next fetch.
- Reset mid-operation (WAIT or RESP): returns immediately to IDLE with all outputs at reset values. The pending fetch is dropped and not counted.
- Width rule: fetch_count is 16-bit unsigned and holds at FFFF.

Test Plan:
- Preload mem[5]=16'h1234, LATENCY=1; PC=5, instrmem_rd pulse -> next cycle complete_instr=1, instr_dout=16'h1234, fetch_count=1, busy low one cycle later.
- LATENCY=4; PC=3 (mem[3]=16'hABCD) held with instrmem_rd=1 for 12 cycles -> complete_instr pulses at cycles 4 and 9 after the first acceptance, each with 16'hABCD; fetch_count=2.
- ADDR_W=8, PC=16'h0100 -> complete_instr=1, addr_err=1, instr_dout=ERR_WORD (16'h0000).
- mem[7]=16'h1111; in the RESP cycle for PC=7, ld_en writes 16'h2222 to addr 7 -> instr_dout=16'h1111; next fetch of 7 returns 16'h2222.
- LATENCY=4; assert reset in the 2nd WAIT cycle -> all outputs 0 asynchronously, no complete_instr pulse, fetch_count=0. Preloaded memory still reads back correctly afterwards.
- Force fetch_count to 16'hFFFE via 65534 fetches (or backdoor) and perform 3 more -> fetch_count stays 16'hFFFF.

Source files
------------

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Brief    : LC-3 instruction-memory bus responder with programmable latency,
//            side-band preload port and saturating fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
  parameter int          ADDR_W   = 8,
  parameter int          LATENCY  = 1,
  parameter logic [15:0] ERR_WORD = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       PC,
  input  logic              instrmem_rd,
  output logic [15:0]       instr_dout,
  output logic              complete_instr,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  output logic              addr_err,
  output logic              busy,
  output logic [15:0]       fetch_count
);

  localparam int         MEM_DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] pc_q;
  logic [15:0] dout_q;
  logic        complete_q;
  logic        addr_err_q;
  logic        busy_q;
  logic [15:0] fetch_count_q;
  logic [15:0] mem_q [MEM_DEPTH];

  logic [15:0] w_rd_pc;
  logic [15:0] w_rd_word;
  logic        w_oob;
  logic        w_enter_resp;

  // The response word is registered on the edge that enters RESP, so with
  // LATENCY=1 the address comes straight from PC rather than pc_q.
  assign w_rd_pc      = (state_q == S_IDLE) ? PC : pc_q;
  assign w_rd_word    = mem_q[w_rd_pc[ADDR_W-1:0]];
  assign w_enter_resp = ((state_q == S_IDLE) && instrmem_rd && (LATENCY == 1)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd1));

  generate
    if (ADDR_W < 16) begin : g_oob_chk
      assign w_oob = |w_rd_pc[15:ADDR_W];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      pc_q          <= 16'h0000;
      dout_q        <= 16'h0000;
      complete_q    <= 1'b0;
      addr_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      complete_q <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instrmem_rd) begin
            pc_q    <= PC;
            cnt_q   <= LAT_M1;
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (w_enter_resp) begin
        complete_q <= 1'b1;
        addr_err_q <= w_oob;
        dout_q     <= w_oob ? ERR_WORD : w_rd_word;
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_q <= fetch_count_q + 16'd1;
        end
      end
    end
  end

  // Memory is deliberately outside the reset domain so preloads survive reset.
  always_ff @(posedge clock) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign instr_dout     = dout_q;
  assign complete_instr = complete_q;
  assign addr_err       = addr_err_q;
  assign busy           = busy_q;
  assign fetch_count    = fetch_count_q;

endmodule
`default_nettype wire
